uart_tx_serializer: RTL and testbench

Byte-level UART transmitter that sits directly downstream of the command interface block. It accepts one DATA_WIDTH-bit word per `tx_en` strobe and shifts it out on `uart_txd` as an asynchronous serial frame: start bit, data LSB first, optional parity, one stop bit. It returns a single-cycle `tx_done` when the frame completes. All outputs are registered, and the line idles high.

---
 rtl/uart_tx_serializer.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, LSB-first data, optional parity, one stop bit
module uart_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BPS          = 115_200,
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_en,
  output logic                  tx_done,
  output logic                  tx_busy,
  output logic                  uart_txd
);

  // Clock cycles per line bit, truncated.
  localparam int N     = SYS_CLK_FREQ / BPS;
  localparam int CNT_W = (N < 2) ? 1 : $clog2(N);
  localparam int IDX_W = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic             ODD_SEL  = (PARITY_ODD != 0);
  localparam logic             HAS_PAR  = (PARITY_EN != 0);

  // A bit period shorter than two clocks cannot be timed by the baud counter.
  if (N < 2) begin : g_bad_rate
    $error("uart_tx_serializer: SYS_CLK_FREQ/BPS must be at least 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("uart_tx_serializer: DATA_WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  // Last clock of the current bit period.
  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic; line level is computed for the state being entered so
  // the registered output lines up with the state with no extra latency.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    txd_d    = txd_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_en) begin
          state_d  = S_START;
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ODD_SEL;
          cnt_d    = '0;
          idx_d    = '0;
          txd_d    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            if (HAS_PAR) begin
              state_d = S_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            txd_d = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          txd_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en   [4];
  logic [7:0] dat  [4];
  logic       txd  [4];
  logic       busy [4];
  logic       done [4];
  int         checks;
  int         errors;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_WIDTH(8), .BPS(10), .SYS_CLK_FREQ(40), .PARITY_EN(0), .PARITY_ODD(0)) u_plain (
    .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_en(en[0]),
    .tx_done(done[0]), .tx_busy(busy[0]), .uart_txd(txd[0]));

  uart_tx_serializer #(.DATA_WIDTH(8), .BPS(10), .SYS_CLK_FREQ(40), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_en(en[1]),
    .tx_done(done[1]), .tx_busy(busy[1]), .uart_txd(txd[1]));

  uart_tx_serializer #(.DATA_WIDTH(8), .BPS(10), .SYS_CLK_FREQ(40), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_en(en[2]),
    .tx_done(done[2]), .tx_busy(busy[2]), .uart_txd(txd[2]));

  uart_tx_serializer u_dflt (
    .clk(clk), .rst(rst), .tx_data(dat[3]), .tx_en(en[3]),
    .tx_done(done[3]), .tx_busy(busy[3]), .uart_txd(txd[3]));

  task automatic start_frame(input int idx, input logic [7:0] d);
    @(negedge clk);
    dat[idx] = d;
    en[idx]  = 1'b1;
  endtask

  task automatic check_frame(input int idx, input int n, input int nb, input logic [10:0] exp,
                             input logic hold_en, input logic [7:0] new_data,
                             input int poke_cycle, input string name);
    int total;
    total = nb * n;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c <= total) begin
        checks++;
        if (txd[idx] !== exp[(c-1)/n]) begin
          errors++;
          $display("FAIL %s txd at T+%0d: got %b want %b", name, c, txd[idx], exp[(c-1)/n]);
        end
        checks++;
        if (busy[idx] !== 1'b1) begin
          errors++;
          $display("FAIL %s busy at T+%0d: got %b want 1", name, c, busy[idx]);
        end
        checks++;
        if (done[idx] !== 1'b0) begin
          errors++;
          $display("FAIL %s done early at T+%0d: got %b want 0", name, c, done[idx]);
        end
      end else begin
        checks++;
        if (done[idx] !== 1'b1) begin
          errors++;
          $display("FAIL %s done at T+%0d: got %b want 1", name, c, done[idx]);
        end
        checks++;
        if (busy[idx] !== 1'b0) begin
          errors++;
          $display("FAIL %s busy in done cycle T+%0d: got %b want 0", name, c, busy[idx]);
        end
        checks++;
        if (txd[idx] !== 1'b1) begin
          errors++;
          $display("FAIL %s txd in done cycle T+%0d: got %b want 1", name, c, txd[idx]);
        end
      end
      if (c == 1) begin
        dat[idx] = new_data;
        if (!hold_en) en[idx] = 1'b0;
      end
      if (c == poke_cycle) begin
        en[idx]  = 1'b1;
        dat[idx] = 8'hFF;
      end
      if (poke_cycle > 0 && c == poke_cycle + 1) en[idx] = 1'b0;
    end
  endtask

  task automatic check_idle(input int idx, input int cycles, input string name);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checks++;
      if (txd[idx] !== 1'b1 || busy[idx] !== 1'b0 || done[idx] !== 1'b0) begin
        errors++;
        $display("FAIL %s idle cycle %0d: got txd=%b busy=%b done=%b want 1/0/0",
                 name, c, txd[idx], busy[idx], done[idx]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txd[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: got txd=%b busy=%b done=%b want 1/0/0", i, txd[i], busy[i], done[i]);
      end
    end
    en[0]  = 1'b1;
    dat[0] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || txd[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority: got busy=%b txd=%b want 0/1", busy[0], txd[0]);
    end
    en[0] = 1'b0;
    rst   = 1'b0;
    check_idle(0, 3, "post_reset");
  endtask

  task automatic test_basic();
    start_frame(0, 8'hA5);
    check_frame(0, 4, 10, 11'b0_1_10100101_0, 1'b0, 8'hA5, 0, "basic_A5");
    check_idle(0, 2, "basic_after");
  endtask

  task automatic test_parity();
    start_frame(1, 8'hA5);
    check_frame(1, 4, 11, 11'b1_0_10100101_0, 1'b0, 8'hA5, 0, "parity_even");
    check_idle(1, 2, "parity_even_after");
    start_frame(2, 8'hA5);
    check_frame(2, 4, 11, 11'b1_1_10100101_0, 1'b0, 8'hA5, 0, "parity_odd");
    check_idle(2, 2, "parity_odd_after");
  endtask

  task automatic test_ignore_busy();
    start_frame(0, 8'h3C);
    check_frame(0, 4, 10, 11'b0_1_00111100_0, 1'b0, 8'h3C, 10, "ignore_busy");
    check_idle(0, 12, "ignore_busy_after");
  endtask

  task automatic test_back_to_back();
    start_frame(0, 8'h01);
    check_frame(0, 4, 10, 11'b0_1_00000001_0, 1'b1, 8'h80, 0, "b2b_first");
    check_frame(0, 4, 10, 11'b0_1_10000000_0, 1'b0, 8'h80, 0, "b2b_second");
    check_idle(0, 6, "b2b_after");
  endtask

  task automatic test_reset_mid_frame();
    start_frame(0, 8'h5A);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) en[0] = 1'b0;
    end
    checks++;
    if (txd[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset data_bit3: got %b want 1", txd[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset abort: got txd=%b busy=%b done=%b want 1/0/0", txd[0], busy[0], done[0]);
    end
    rst = 1'b0;
    check_idle(0, 40, "mid_reset_no_done");
    start_frame(0, 8'hC3);
    check_frame(0, 4, 10, 11'b0_1_11000011_0, 1'b0, 8'hC3, 0, "after_reset_C3");
  endtask

  task automatic test_default_params();
    start_frame(3, 8'h55);
    check_frame(3, 434, 10, 11'b0_1_01010101_0, 1'b0, 8'h55, 0, "default_55");
    check_idle(3, 2, "default_after");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i]  = 1'b0;
      dat[i] = 8'h00;
    end
    test_reset();
    test_basic();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_default_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
